sram_arb_ctrl: RTL

SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

---
 rtl/sram_arb_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sram_arb_ctrl.sv
// Two-port round-robin arbiter and power-state controller for a single-port SRAM macro.
// Optional contention counter is built when SRAM_ARB_CONFLICT_CNT_EN is defined.
module sram_arb_ctrl #(
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [10:0] addr0,
    input  logic [10:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [31:0] wben0,
    input  logic [31:0] wben1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    input  logic        sd_req,
    output logic        mem_ceb,
    output logic        mem_web,
    output logic [10:0] mem_a,
    output logic [31:0] mem_d,
    output logic [31:0] mem_bweb,
    output logic        mem_slp,
    output logic        mem_sd,
    output logic        mem_bist,
    output logic        mem_awt,
    input  logic [31:0] mem_q,
    output logic [15:0] conflict_cnt
);

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        SLEEP    = 2'd1,
        WAKE     = 2'd2,
        SHUTDOWN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  idle_cnt;
    logic [7:0]  idle_cnt_next;
    logic [3:0]  wake_cnt;
    logic [3:0]  wake_cnt_next;
    logic        rr_ptr;
    logic        owner;
    logic        grant0;
    logic        grant1;
    logic        any_req;
    logic        in_flight;

    assign any_req   = req0 | req1;
    assign in_flight = ~mem_ceb | rvalid0 | rvalid1;

    always_comb begin
        state_next    = state;
        idle_cnt_next = '0;
        wake_cnt_next = '0;
        grant0        = 1'b0;
        grant1        = 1'b0;
        case (state)
            ACTIVE: begin
                if (sd_req) begin
                    if (!in_flight) begin
                        state_next = SHUTDOWN;
                    end
                end else if (any_req) begin
                    if (req0 && req1) begin
                        grant0 = ~rr_ptr;
                        grant1 = rr_ptr;
                    end else begin
                        grant0 = req0;
                        grant1 = req1;
                    end
                end else if (in_flight) begin
                    idle_cnt_next = idle_cnt;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next = SLEEP;
                end else begin
                    idle_cnt_next = idle_cnt + 8'd1;
                end
            end
            SLEEP: begin
                if (sd_req) begin
                    state_next = SHUTDOWN;
                end else if (any_req) begin
                    state_next = WAKE;
                end
            end
            WAKE: begin
                if (sd_req) begin
                    state_next = SHUTDOWN;
                end else if (wake_cnt == WAKE_LAST) begin
                    state_next = ACTIVE;
                end else begin
                    wake_cnt_next = wake_cnt + 4'd1;
                end
            end
            SHUTDOWN: begin
                if (!sd_req) begin
                    state_next = WAKE;
                end
            end
        endcase
    end

    // Grants are gated by reset so they read 0 while RSTB is held low.
    assign gnt0 = RSTB & grant0;
    assign gnt1 = RSTB & grant1;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_cnt_next;
            wake_cnt <= wake_cnt_next;
            if (grant0) begin
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                rr_ptr <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            mem_ceb  <= 1'b1;
            mem_web  <= 1'b1;
            mem_a    <= '0;
            mem_d    <= '0;
            mem_bweb <= '1;
            owner    <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            if (grant0) begin
                mem_ceb  <= 1'b0;
                mem_web  <= ~we0;
                mem_a    <= addr0;
                mem_d    <= wdata0;
                mem_bweb <= ~wben0;
                owner    <= 1'b0;
            end else if (grant1) begin
                mem_ceb  <= 1'b0;
                mem_web  <= ~we1;
                mem_a    <= addr1;
                mem_d    <= wdata1;
                mem_bweb <= ~wben1;
                owner    <= 1'b1;
            end else begin
                mem_ceb <= 1'b1;
                mem_web <= 1'b1;
            end
            // Macro returns read data one cycle after the registered access.
            rvalid0 <= ~mem_ceb & mem_web & ~owner;
            rvalid1 <= ~mem_ceb & mem_web & owner;
        end
    end

    assign rdata    = mem_q;
    assign mem_slp  = (state == SLEEP);
    assign mem_sd   = (state == SHUTDOWN);
    assign mem_bist = 1'b0;
    assign mem_awt  = 1'b0;

`ifdef SRAM_ARB_CONFLICT_CNT_EN
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            conflict_cnt <= '0;
        end else if (req0 && req1 && !(grant0 && grant1) && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule
